traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: watches four intersection lamps (M1, M2, MT, S) and
// raises sticky error flags for bad encodings, illegal colour sequences,
// conflicting movements, bad green/yellow durations and a stalled controller.
// The class and lamp of the first error seen are latched for diagnosis.

package traffic_light_monitor_pkg;
   localparam logic [2:0] C_RED    = 3'b100;
   localparam logic [2:0] C_YELLOW = 3'b010;
   localparam logic [2:0] C_GREEN  = 3'b001;

   localparam logic [2:0] CODE_NONE     = 3'd0;
   localparam logic [2:0] CODE_ENCODE   = 3'd1;
   localparam logic [2:0] CODE_SEQ      = 3'd2;
   localparam logic [2:0] CODE_CONFLICT = 3'd3;
   localparam logic [2:0] CODE_TIMING   = 3'd4;
   localparam logic [2:0] CODE_STUCK    = 3'd5;

   // Per-lamp observations for the current sample
   typedef struct packed {
      logic fresh;    // first sample since rst/clr
      logic changed;  // value differs from the previous sample
      logic non_red;  // lamp permits movement (anything but solid red)
      logic enc_err;  // value is not one of R/Y/G
      logic seq_err;  // illegal colour transition
      logic tim_err;  // green too short or yellow wrong length
   } lamp_stat_t;
endpackage

// Per-lamp checker: keeps previous value, valid bit and a saturating dwell
// counter, and reports this sample's errors combinationally.
module traffic_light_lamp_chk
   import traffic_light_monitor_pkg::*;
#(
   parameter int MIN_GREEN  = 3,
   parameter int YELLOW_LEN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [2:0] light,
   output lamp_stat_t stat
);
   localparam logic [7:0] MIN_G8 = 8'(MIN_GREEN);
   localparam logic [7:0] YEL_8  = 8'(YELLOW_LEN);

   logic [2:0] prev;
   logic       valid;
   logic [7:0] dwell;
   logic       legal;
   logic       prev_legal;
   logic       diff;
   logic       legal_step;

   // Classify the current sample against the stored history
   always_comb begin
      legal      = (light == C_RED) || (light == C_YELLOW) || (light == C_GREEN);
      prev_legal = (prev == C_RED) || (prev == C_YELLOW) || (prev == C_GREEN);
      diff       = (light != prev);
      legal_step = ((prev == C_RED)    && (light == C_GREEN))  ||
                   ((prev == C_GREEN)  && (light == C_YELLOW)) ||
                   ((prev == C_YELLOW) && (light == C_RED));
      stat         = '0;
      stat.fresh   = !valid;
      stat.changed = valid && diff;
      stat.non_red = (light != C_RED);
      stat.enc_err = !legal;
      // Sequence and timing are judged only between two well-formed values
      // with history available.
      if (valid && legal && prev_legal && diff) begin
         stat.seq_err = !legal_step;
         if ((prev == C_GREEN) && (dwell < MIN_G8))
            stat.tim_err = 1'b1;
         if ((prev == C_YELLOW) && (dwell != YEL_8))
            stat.tim_err = 1'b1;
      end
   end

   // History update: prev always follows the lamp, dwell restarts on change
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         valid <= 1'b0;
         prev  <= 3'b000;
         dwell <= 8'd0;
      end else begin
         valid <= 1'b1;
         prev  <= light;
         if (!valid || diff)
            dwell <= 8'd1;
         else if (dwell != 8'hFF)
            dwell <= dwell + 8'd1;
      end
   end
endmodule

module traffic_light_monitor
   import traffic_light_monitor_pkg::*;
#(
   parameter int MIN_GREEN  = 3,
   parameter int YELLOW_LEN = 2,
   parameter int WDOG       = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_S,
   input  logic       clr,
   output logic       err_encode,
   output logic       err_seq,
   output logic       err_conflict,
   output logic       err_timing,
   output logic       err_stuck,
   output logic       err_any,
   output logic [2:0] first_code,
   output logic [1:0] first_light
);
   localparam int          NUM_LANES = 4;
   localparam logic [15:0] WDOG_LIM  = 16'(WDOG);

   // Lane order fixes lamp priority: 0=M1, 1=M2, 2=MT, 3=S
   logic [NUM_LANES-1:0][2:0] lights;
   lamp_stat_t                stat [NUM_LANES];
   logic [NUM_LANES-1:0]      fresh_v, chg_v, nonred_v, enc_v, seq_v, tim_v;

   logic        any_fresh;
   logic        any_chg;
   logic        conflict_det;
   logic        stuck_det;
   logic [15:0] quiet_cnt;
   logic [2:0]  code_det;
   logic [1:0]  lamp_det;

   assign lights = {light_S, light_MT, light_M2, light_M1};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lamp
      traffic_light_lamp_chk #(
         .MIN_GREEN  (MIN_GREEN),
         .YELLOW_LEN (YELLOW_LEN)
      ) u_chk (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr),
         .light (lights[g]),
         .stat  (stat[g])
      );
      assign fresh_v[g]  = stat[g].fresh;
      assign chg_v[g]    = stat[g].changed;
      assign nonred_v[g] = stat[g].non_red;
      assign enc_v[g]    = stat[g].enc_err;
      assign seq_v[g]    = stat[g].seq_err;
      assign tim_v[g]    = stat[g].tim_err;
   end

   function automatic logic [1:0] lowest_lamp(input logic [NUM_LANES-1:0] v);
      lowest_lamp = 2'd0;
      for (int i = NUM_LANES - 1; i >= 0; i--)
         if (v[i]) lowest_lamp = 2'(i);
   endfunction

   // Global detectors: conflicting movements and stalled controller
   always_comb begin
      any_fresh    = |fresh_v;
      any_chg      = |chg_v;
      // Side road against any main movement; turn lane against main road 2
      conflict_det = (nonred_v[3] && (|nonred_v[2:0])) ||
                     (nonred_v[2] && nonred_v[1]);
      // Fires once, on the sample that brings the quiet count up to WDOG
      stuck_det    = !any_fresh && !any_chg && (quiet_cnt == WDOG_LIM - 16'd1);
   end

   // Priority-encode this sample's errors into a class and lamp
   always_comb begin
      code_det = CODE_NONE;
      lamp_det = 2'd0;
      if (|enc_v) begin
         code_det = CODE_ENCODE;
         lamp_det = lowest_lamp(enc_v);
      end else if (|seq_v) begin
         code_det = CODE_SEQ;
         lamp_det = lowest_lamp(seq_v);
      end else if (conflict_det) begin
         code_det = CODE_CONFLICT;
      end else if (|tim_v) begin
         code_det = CODE_TIMING;
         lamp_det = lowest_lamp(tim_v);
      end else if (stuck_det) begin
         code_det = CODE_STUCK;
      end
   end

   // Quiet counter: cycles since any lamp last changed, holds at WDOG
   always_ff @(posedge clk) begin
      if (rst || clr)
         quiet_cnt <= 16'd0;
      else if (any_fresh || any_chg)
         quiet_cnt <= 16'd0;
      else if (quiet_cnt != WDOG_LIM)
         quiet_cnt <= quiet_cnt + 16'd1;
   end

   // Sticky flags and first-error capture
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_encode   <= 1'b0;
         err_seq      <= 1'b0;
         err_conflict <= 1'b0;
         err_timing   <= 1'b0;
         err_stuck    <= 1'b0;
         first_code   <= CODE_NONE;
         first_light  <= 2'd0;
      end else begin
         err_encode   <= err_encode   | (|enc_v);
         err_seq      <= err_seq      | (|seq_v);
         err_conflict <= err_conflict | conflict_det;
         err_timing   <= err_timing   | (|tim_v);
         err_stuck    <= err_stuck    | stuck_det;
         if ((first_code == CODE_NONE) && (code_det != CODE_NONE)) begin
            first_code  <= code_det;
            first_light <= lamp_det;
         end
      end
   end

   assign err_any = err_encode | err_seq | err_conflict | err_timing | err_stuck;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized and directed bench for traffic_light_monitor, checked against a
// behavioural model of the monitoring rules kept in the bench.
module tb_traffic_light_monitor;
   localparam int MIN_GREEN  = 3;
   localparam int YELLOW_LEN = 2;
   localparam int WDOG       = 64;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            clr = 1'b0;
   logic [3:0][2:0] lv  = '0;
   logic            err_encode, err_seq, err_conflict, err_timing, err_stuck, err_any;
   logic [2:0]      first_code;
   logic [1:0]      first_light;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .MIN_GREEN  (MIN_GREEN),
      .YELLOW_LEN (YELLOW_LEN),
      .WDOG       (WDOG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .light_M1     (lv[0]),
      .light_M2     (lv[1]),
      .light_MT     (lv[2]),
      .light_S      (lv[3]),
      .clr          (clr),
      .err_encode   (err_encode),
      .err_seq      (err_seq),
      .err_conflict (err_conflict),
      .err_timing   (err_timing),
      .err_stuck    (err_stuck),
      .err_any      (err_any),
      .first_code   (first_code),
      .first_light  (first_light)
   );

   typedef struct packed {
      logic       enc, seq, con, tim, stk;
      logic [2:0] code;
      logic [1:0] lamp;
   } exp_t;

   // Model state: history of what each lamp showed and for how long
   exp_t       m, exp_pend, exp_cur;
   int         run_len [4];
   logic [2:0] last [4];
   bit         seen;
   int         quiet;
   int         n_vec = 0;
   int         n_err = 0;
   bit         chk_en = 1'b0;
   logic [10:0] act_v, want_v;

   function automatic logic [2:0] succ(input logic [2:0] v);
      case (v)
         R:       return G;
         G:       return Y;
         Y:       return R;
         default: return R;
      endcase
   endfunction

   function automatic bit is_legal(input logic [2:0] v);
      return (v == R) || (v == Y) || (v == G);
   endfunction

   function automatic logic [1:0] low_idx(input bit [3:0] b);
      for (int i = 0; i < 4; i++)
         if (b[i]) return 2'(i);
      return 2'd0;
   endfunction

   function automatic logic [2:0] pick_legal();
      case ($urandom_range(0, 2))
         0:       return R;
         1:       return Y;
         default: return G;
      endcase
   endfunction

   // Expected outputs after the coming edge, given the inputs now applied
   task automatic model_step();
      bit [3:0] e_enc, e_seq, e_tim;
      bit       e_con, e_stk, chg;
      if (rst || clr) begin
         m     = '0;
         seen  = 1'b0;
         quiet = 0;
         for (int i = 0; i < 4; i++) begin
            run_len[i] = 0;
            last[i]    = 3'b000;
         end
         exp_pend = m;
         return;
      end
      e_enc = '0; e_seq = '0; e_tim = '0; chg = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!is_legal(lv[i]))
            e_enc[i] = 1'b1;
         else if (seen && (lv[i] != last[i]) && is_legal(last[i])) begin
            if (lv[i] != succ(last[i])) e_seq[i] = 1'b1;
            if ((last[i] == G) && (run_len[i] < MIN_GREEN)) e_tim[i] = 1'b1;
            if ((last[i] == Y) && (run_len[i] != YELLOW_LEN)) e_tim[i] = 1'b1;
         end
         if (seen && (lv[i] != last[i])) chg = 1'b1;
      end
      e_con = ((lv[3] != R) && ((lv[0] != R) || (lv[1] != R) || (lv[2] != R))) ||
              ((lv[2] != R) && (lv[1] != R));
      quiet = (!seen || chg) ? 0 : quiet + 1;
      e_stk = (quiet == WDOG);
      for (int i = 0; i < 4; i++) begin
         run_len[i] = (!seen || (lv[i] != last[i])) ? 1 : run_len[i] + 1;
         last[i]    = lv[i];
      end
      seen  = 1'b1;
      m.enc = m.enc | (|e_enc);
      m.seq = m.seq | (|e_seq);
      m.con = m.con | e_con;
      m.tim = m.tim | (|e_tim);
      m.stk = m.stk | e_stk;
      if (m.code == 3'd0) begin
         if (|e_enc)      begin m.code = 3'd1; m.lamp = low_idx(e_enc); end
         else if (|e_seq) begin m.code = 3'd2; m.lamp = low_idx(e_seq); end
         else if (e_con)  begin m.code = 3'd3; m.lamp = 2'd0; end
         else if (|e_tim) begin m.code = 3'd4; m.lamp = low_idx(e_tim); end
         else if (e_stk)  begin m.code = 3'd5; m.lamp = 2'd0; end
      end
      exp_pend = m;
   endtask

   task automatic step(input logic [2:0] m1, m2, mt, s, input logic c, input logic r);
      lv  = {s, mt, m2, m1};
      clr = c;
      rst = r;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   // Expected value becomes current on the edge that samples its inputs
   initial forever begin
      @(posedge clk);
      exp_cur = exp_pend;
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         act_v  = {err_encode, err_seq, err_conflict, err_timing, err_stuck, err_any,
                   first_code, first_light};
         want_v = {exp_cur.enc, exp_cur.seq, exp_cur.con, exp_cur.tim, exp_cur.stk,
                   (exp_cur.enc | exp_cur.seq | exp_cur.con | exp_cur.tim | exp_cur.stk),
                   exp_cur.code, exp_cur.lamp};
         n_vec++;
         if (act_v !== want_v) begin
            n_err++;
            $display("FAIL outputs @%0t: got %b, expected %b", $time, act_v, want_v);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] nv [4];
      int         r;
      int         hold;

      // Reset with garbage on the lamps
      step(3'b111, 3'b000, G, G, 1'b0, 1'b1);
      chk_en = 1'b1;
      step(R, R, R, R, 1'b0, 1'b1);
      check("reset_err_any", err_any, 0);
      check("reset_first_code", first_code, 0);
      check("reset_first_light", first_light, 0);

      // Legal cycle three times
      step(R, R, R, R, 1'b0, 1'b0);
      repeat (3) begin
         repeat (5) step(G, G, R, R, 1'b0, 1'b0);
         repeat (2) step(Y, Y, R, R, 1'b0, 1'b0);
         repeat (5) step(R, R, R, G, 1'b0, 1'b0);
         repeat (2) step(R, R, R, Y, 1'b0, 1'b0);
      end
      step(R, R, R, R, 1'b0, 1'b0);
      check("legal_err_any", err_any, 0);

      // Conflict M1 green with S green
      step(R, R, R, R, 1'b1, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      step(G, R, R, G, 1'b0, 1'b0);
      check("conflict_flag", err_conflict, 1);
      check("conflict_code", first_code, 3);
      check("conflict_light", first_light, 0);

      // M2 red straight to yellow
      step(R, R, R, R, 1'b1, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      step(R, Y, R, R, 1'b0, 1'b0);
      check("seq_flag", err_seq, 1);
      check("seq_code", first_code, 2);
      check("seq_light", first_light, 1);
      check("seq_no_timing", err_timing, 0);

      // Short green on MT, then long yellow on S
      step(R, R, R, R, 1'b1, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      repeat (2) step(R, R, G, R, 1'b0, 1'b0);
      step(R, R, Y, R, 1'b0, 1'b0);
      check("timing_flag", err_timing, 1);
      check("timing_code", first_code, 4);
      check("timing_light", first_light, 2);
      step(R, R, Y, R, 1'b0, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      repeat (5) step(R, R, R, G, 1'b0, 1'b0);
      repeat (3) step(R, R, R, Y, 1'b0, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      check("timing2_seq", err_seq, 0);
      check("timing2_conflict", err_conflict, 0);
      check("timing2_code", first_code, 4);

      // Bad encoding on S, then everything frozen
      step(R, R, R, R, 1'b1, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      step(R, R, R, 3'b011, 1'b0, 1'b0);
      check("encode_flag", err_encode, 1);
      check("encode_code", first_code, 1);
      check("encode_light", first_light, 3);
      step(R, R, R, R, 1'b0, 1'b0);
      repeat (WDOG - 1) step(R, R, R, R, 1'b0, 1'b0);
      check("stuck_before", err_stuck, 0);
      step(R, R, R, R, 1'b0, 1'b0);
      check("stuck_flag", err_stuck, 1);
      check("stuck_code_kept", first_code, 1);

      // Clear pulse, then reset in the middle of a green
      step(R, R, R, R, 1'b1, 1'b0);
      check("clr_err_any", err_any, 0);
      check("clr_first_code", first_code, 0);
      step(R, R, R, R, 1'b0, 1'b0);
      step(G, R, R, R, 1'b0, 1'b0);
      step(G, R, R, R, 1'b0, 1'b1);
      check("rst_err_any", err_any, 0);
      step(Y, R, R, R, 1'b0, 1'b0);
      step(Y, R, R, R, 1'b0, 1'b0);
      step(R, R, R, R, 1'b0, 1'b0);
      check("rst_no_timing", err_timing, 0);
      check("rst_err_any_after", err_any, 0);

      // Random lamp traffic with occasional clear/reset
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 99);
            if (r < 78)      nv[i] = lv[i];
            else if (r < 92) nv[i] = succ(lv[i]);
            else if (r < 98) nv[i] = pick_legal();
            else             nv[i] = 3'($urandom_range(0, 7));
         end
         step(nv[0], nv[1], nv[2], nv[3],
              $urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0);
      end

      // Frozen lamps around the watchdog boundary
      for (int k = 0; k < 6; k++) begin
         step(R, R, R, R, 1'b1, 1'b0);
         for (int i = 0; i < 4; i++) nv[i] = pick_legal();
         hold = $urandom_range(WDOG - 2, WDOG + 3);
         repeat (hold) step(nv[0], nv[1], nv[2], nv[3], 1'b0, 1'b0);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
